// File: rtl/mod_reduct_solinas3_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mod_reduct_solinas3_pipe (+ mod_reduct_solinas3_pipe_pkg)
// Brief    : Pipelined reduction of a 2*MOD_W-bit product modulo the Solinas
//            prime p = 2^MOD_W - 2^INT_POW + 1. It uses three folds and one
//            conditional subtract. Optional macro
//            MOD_REDUCT_SOLINAS3_PIPE_IN_REG_EN adds an input register stage.
// Revision : 1.0 - initial release
// ============================================================================

package mod_reduct_solinas3_pipe_pkg;
`ifdef MOD_REDUCT_SOLINAS3_PIPE_IN_REG_EN
    localparam int LATENCY = 5;
`else
    localparam int LATENCY = 4;
`endif

    function automatic int get_latency();
        return LATENCY;
    endfunction
endpackage

module mod_reduct_solinas3_pipe #(
    parameter int MOD_W   = 64,
    parameter int INT_POW = 32,
    parameter int SIDE_W  = 0
) (
    input  logic                               clk,
    input  logic                               s_rst_n,
    input  logic [2*MOD_W-1:0]                 a,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
    input  logic                               in_avail,
    output logic [MOD_W-1:0]                   z,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side,
    output logic                               out_avail
);
    localparam int c_side_w = (SIDE_W > 0) ? SIDE_W : 1;
    localparam int c_w1     = MOD_W + INT_POW + 1;
    localparam int c_w2     = MOD_W + 2;
    localparam int c_w3     = MOD_W + 1;
    localparam logic [c_w3-1:0] c_p =
        (c_w3'(1) << MOD_W) - (c_w3'(1) << INT_POW) + c_w3'(1);

    if (INT_POW < 1 || INT_POW > MOD_W / 2) begin : g_param_check
        $fatal(1, "mod_reduct_solinas3_pipe: INT_POW=%0d outside [1, MOD_W/2]", INT_POW);
    end

    logic [2*MOD_W-1:0]  w_a_s0;
    logic [c_side_w-1:0] w_side_s0;
    logic                w_avail_s0;

`ifdef MOD_REDUCT_SOLINAS3_PIPE_IN_REG_EN
    logic [2*MOD_W-1:0]  r_a_in;
    logic [c_side_w-1:0] r_side_in;
    logic                r_avail_in;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_a_in     <= '0;
            r_side_in  <= '0;
            r_avail_in <= 1'b0;
        end else begin
            r_avail_in <= in_avail;
            if (in_avail) begin
                r_a_in    <= a;
                r_side_in <= in_side;
            end
        end
    end

    assign w_a_s0     = r_a_in;
    assign w_side_s0  = r_side_in;
    assign w_avail_s0 = r_avail_in;
`else
    assign w_a_s0     = a;
    assign w_side_s0  = in_side;
    assign w_avail_s0 = in_avail;
`endif

    logic [c_w1-1:0]  r_x1;
    logic [c_w2-1:0]  r_x2;
    logic [c_w3-1:0]  r_x3;
    logic [3:0]       r_avail;

    logic [MOD_W-1:0] w_hi1;
    logic [INT_POW:0] w_hi2;
    logic [1:0]       w_hi3;
    logic [c_w1-1:0]  w_x1;
    logic [c_w2-1:0]  w_x2;
    logic [c_w3-1:0]  w_x3;
    logic [MOD_W-1:0] w_z;

    // fold(x) = lo + hi*(2^INT_POW - 1), with the multiply done as (hi << INT_POW) - hi
    assign w_hi1 = w_a_s0[2*MOD_W-1:MOD_W];
    assign w_x1  = c_w1'({w_hi1, {INT_POW{1'b0}}}) - c_w1'(w_hi1)
                 + c_w1'(w_a_s0[MOD_W-1:0]);

    assign w_hi2 = r_x1[c_w1-1:MOD_W];
    assign w_x2  = c_w2'({w_hi2, {INT_POW{1'b0}}}) - c_w2'(w_hi2)
                 + c_w2'(r_x1[MOD_W-1:0]);

    assign w_hi3 = r_x2[c_w2-1:MOD_W];
    assign w_x3  = c_w3'({w_hi3, {INT_POW{1'b0}}}) - c_w3'(w_hi3)
                 + c_w3'(r_x2[MOD_W-1:0]);

    // x3 < 2p, so the difference always fits in MOD_W bits when it is selected
    assign w_z = (r_x3 >= c_p) ? (r_x3[MOD_W-1:0] - c_p[MOD_W-1:0])
                               : r_x3[MOD_W-1:0];

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_avail <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_x3    <= '0;
            z       <= '0;
        end else begin
            r_avail <= {r_avail[2:0], w_avail_s0};
            if (w_avail_s0) begin
                r_x1 <= w_x1;
            end
            if (r_avail[0]) begin
                r_x2 <= w_x2;
            end
            if (r_avail[1]) begin
                r_x3 <= w_x3;
            end
            if (r_avail[2]) begin
                z <= w_z;
            end
        end
    end

    assign out_avail = r_avail[3];

    if (SIDE_W > 0) begin : g_side
        logic [c_side_w-1:0] r_side_s1;
        logic [c_side_w-1:0] r_side_s2;
        logic [c_side_w-1:0] r_side_s3;

        always_ff @(posedge clk or negedge s_rst_n) begin
            if (!s_rst_n) begin
                r_side_s1 <= '0;
                r_side_s2 <= '0;
                r_side_s3 <= '0;
                out_side  <= '0;
            end else begin
                if (w_avail_s0) begin
                    r_side_s1 <= w_side_s0;
                end
                if (r_avail[0]) begin
                    r_side_s2 <= r_side_s1;
                end
                if (r_avail[1]) begin
                    r_side_s3 <= r_side_s2;
                end
                if (r_avail[2]) begin
                    out_side <= r_side_s3;
                end
            end
        end
    end else begin : g_no_side
        logic w_unused_side;

        assign w_unused_side = ^w_side_s0;
        assign out_side      = '0;
    end

endmodule

`default_nettype wire
